// File: rtl/cam_lookup_ctrl.sv
// cam_lookup_ctrl: request-side sequencer for a 16-entry byte CAM.
// Initialises the CAM after reset, runs search / check / optional allocate
// per request and returns index/hit/alloc over a valid/ready handshake.
// Optional feature macro: CAM_LOOKUP_STATS_EN adds saturating hit/miss counters.
module cam_lookup_ctrl #(
  parameter int unsigned NB_MEM    = 16,
  parameter int unsigned SIZE_ADDR = 4,
  parameter logic [7:0]  RSVD_KEY  = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  input  logic                 in_alloc,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SIZE_ADDR-1:0] res_index,
  output logic                 res_hit,
  output logic                 res_alloc,
  output logic                 cam_enable,
  output logic                 cam_write,
  output logic [4:0]           cam_addr,
  output logic [7:0]           cam_data,
  input  logic [4:0]           cam_out,
`ifdef CAM_LOOKUP_STATS_EN
  output logic [15:0]          hit_cnt,
  output logic [15:0]          miss_cnt,
`endif
  input  logic                 cam_found
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SEARCH,
    ST_CHECK,
    ST_ALLOC,
    ST_RESP
  } state_t;

  state_t state, next_state;

  logic [SIZE_ADDR:0]   init_cnt, init_cnt_d;
  logic [SIZE_ADDR-1:0] victim, victim_d;
  logic [7:0]           key, key_d;
  logic                 alloc_req, alloc_req_d;
  logic                 init_done;
  logic                 transfer;

  logic                 in_ready_d, res_valid_d, res_hit_d, res_alloc_d;
  logic [SIZE_ADDR-1:0] res_index_d;
  logic                 cam_enable_d, cam_write_d;
  logic [4:0]           cam_addr_d;
  logic [7:0]           cam_data_d;

  // Index bits above SIZE_ADDR from the CAM carry no information.
  logic unused_cam_out;
  assign unused_cam_out = ^cam_out;

  assign init_done = (init_cnt == (SIZE_ADDR+1)'(NB_MEM));
  assign transfer  = (state == ST_RESP) && res_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_INIT:   if (init_done) next_state = ST_IDLE;
      ST_IDLE:   if (in_valid) next_state = (in_data == RSVD_KEY) ? ST_RESP : ST_SEARCH;
      ST_SEARCH: next_state = ST_CHECK;
      ST_CHECK:  next_state = (!cam_found && alloc_req) ? ST_ALLOC : ST_RESP;
      ST_ALLOC:  next_state = ST_RESP;
      ST_RESP:   if (res_ready) next_state = ST_IDLE;
      default:   next_state = ST_INIT;
    endcase
  end

  // Outputs are registered; this computes the values they take in the next
  // state so that they line up with the state itself and still reset to zero.
  always_comb begin
    init_cnt_d   = init_cnt;
    victim_d     = victim;
    key_d        = key;
    alloc_req_d  = alloc_req;
    res_index_d  = res_index;
    res_hit_d    = res_hit;
    res_alloc_d  = res_alloc;
    cam_write_d  = 1'b0;
    cam_addr_d   = cam_addr;
    cam_data_d   = cam_data;
    in_ready_d   = (next_state == ST_IDLE);
    res_valid_d  = (next_state == ST_RESP);
    cam_enable_d = (next_state == ST_SEARCH);
    unique case (state)
      ST_INIT: begin
        if (!init_done) begin
          cam_write_d = 1'b1;
          cam_addr_d  = 5'(init_cnt[SIZE_ADDR-1:0]);
          cam_data_d  = RSVD_KEY;
          init_cnt_d  = init_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (in_valid) begin
          key_d       = in_data;
          alloc_req_d = in_alloc;
          cam_data_d  = in_data;
          res_index_d = '0;
          res_hit_d   = 1'b0;
          res_alloc_d = 1'b0;
        end
      end
      ST_CHECK: begin
        if (cam_found) begin
          res_hit_d   = 1'b1;
          res_index_d = cam_out[SIZE_ADDR-1:0];
        end else if (alloc_req) begin
          cam_write_d = 1'b1;
          cam_addr_d  = 5'(victim);
          res_index_d = victim;
          res_alloc_d = 1'b1;
          victim_d    = (victim == SIZE_ADDR'(NB_MEM-1)) ? '0 : victim + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt   <= '0;
      victim     <= '0;
      key        <= '0;
      alloc_req  <= 1'b0;
      in_ready   <= 1'b0;
      res_valid  <= 1'b0;
      res_index  <= '0;
      res_hit    <= 1'b0;
      res_alloc  <= 1'b0;
      cam_enable <= 1'b0;
      cam_write  <= 1'b0;
      cam_addr   <= '0;
      cam_data   <= '0;
    end else begin
      init_cnt   <= init_cnt_d;
      victim     <= victim_d;
      key        <= key_d;
      alloc_req  <= alloc_req_d;
      in_ready   <= in_ready_d;
      res_valid  <= res_valid_d;
      res_index  <= res_index_d;
      res_hit    <= res_hit_d;
      res_alloc  <= res_alloc_d;
      cam_enable <= cam_enable_d;
      cam_write  <= cam_write_d;
      cam_addr   <= cam_addr_d;
      cam_data   <= cam_data_d;
    end
  end

`ifdef CAM_LOOKUP_STATS_EN
  // Saturating hit/miss counters, stepped on each result transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (transfer) begin
      if (res_hit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 1'b1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_transfer;
  assign unused_transfer = transfer;
`endif

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Testbench for cam_lookup_ctrl: behavioural CAM attached to the CAM pins,
// directed steps followed by randomized lookups checked against a key-table model.
module tb_cam_lookup_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_alloc;
  logic [7:0] in_data;
  logic       res_valid, res_ready, res_hit, res_alloc;
  logic [3:0] res_index;
  logic       cam_enable, cam_write, cam_found;
  logic [4:0] cam_addr, cam_out;
  logic [7:0] cam_data;
`ifdef CAM_LOOKUP_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: contents of each slot and the next victim.
  logic [7:0] mkeys [16];
  int         mvictim;
  int         mhits, mmisses;

  // Behavioural CAM storage (not reset).
  logic [7:0] cam_mem [16];

  always #5 clk = ~clk;

  cam_lookup_ctrl #(.NB_MEM(16), .SIZE_ADDR(4), .RSVD_KEY(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_alloc(in_alloc),
    .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index),
    .res_hit(res_hit), .res_alloc(res_alloc),
    .cam_enable(cam_enable), .cam_write(cam_write), .cam_addr(cam_addr),
    .cam_data(cam_data), .cam_out(cam_out),
`ifdef CAM_LOOKUP_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .cam_found(cam_found)
  );

  // Behavioural CAM: write on cam_write, registered search result on cam_enable.
  always @(posedge clk) begin
    logic       f;
    logic [3:0] idx;
    if (cam_write) cam_mem[cam_addr[3:0]] <= cam_data;
    if (cam_enable) begin
      f = 1'b0;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
        if (cam_mem[i] == cam_data) begin
          f = 1'b1;
          idx = 4'(i);
        end
      end
      cam_found <= f;
      cam_out   <= {1'($urandom), idx};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset now, check reset values, release and check the init sweep.
  task automatic reset_and_init();
    rst_n = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b0;
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cam_write", cam_write, 0);
    chk("rst_cam_enable", cam_enable, 0);
    chk("rst_cam_addr", cam_addr, 0);
    chk("rst_cam_data", cam_data, 0);
    chk("rst_res_fields", {res_index, res_hit, res_alloc}, 0);
`ifdef CAM_LOOKUP_STATS_EN
    chk("rst_stats", {hit_cnt, miss_cnt}, 0);
`endif
    for (int i = 0; i < 16; i++) mkeys[i] = 8'hFF;
    mvictim = 0;
    mhits = 0;
    mmisses = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("init_write", cam_write, 1);
      chk("init_addr", cam_addr, i);
      chk("init_data", cam_data, 8'hFF);
      chk("init_ready", {in_ready, cam_enable}, 0);
    end
    tick();
    chk("init_end_write", cam_write, 0);
    chk("init_end_ready", in_ready, 1);
  endtask

  // One lookup, with expectations derived from the key table.
  task automatic lookup(input logic [7:0] k, input logic a, input int hold);
    int exp_lat, exp_en, exp_wr, lat, en_cyc, wr_cyc, both, found_at;
    logic exp_hit, exp_alloc;
    logic [3:0] exp_idx;
    logic [6:0] snap;
    int wait_cyc = 0;
    while (!in_ready && wait_cyc < 40) begin
      tick();
      wait_cyc++;
    end
    chk("ready_before_req", in_ready, 1);

    found_at = -1;
    for (int i = 0; i < 16; i++) if (mkeys[i] == k && k != 8'hFF) found_at = i;
    exp_hit = 1'b0; exp_alloc = 1'b0; exp_idx = 4'd0; exp_en = 1; exp_wr = 0; exp_lat = 3;
    if (k == 8'hFF) begin
      exp_lat = 1; exp_en = 0;
    end else if (found_at >= 0) begin
      exp_hit = 1'b1; exp_idx = 4'(found_at);
    end else if (a) begin
      exp_alloc = 1'b1; exp_idx = 4'(mvictim); exp_wr = 1; exp_lat = 4;
      mkeys[mvictim] = k;
      mvictim = (mvictim + 1) % 16;
    end

    in_valid = 1'b1; in_data = k; in_alloc = a;
    tick();
    in_valid = 1'b0; in_data = 8'($urandom); in_alloc = 1'($urandom);
    lat = 1; en_cyc = 0; wr_cyc = 0; both = 0;
    while (!res_valid && lat < 12) begin
      if (cam_enable) en_cyc++;
      if (cam_write) begin
        wr_cyc++;
        if (cam_addr[4] || cam_data != k) both++;
      end
      if (cam_enable && cam_write) both++;
      if (in_ready) both++;
      tick();
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("cam_enable_cycles", en_cyc, exp_en);
    chk("cam_write_cycles", wr_cyc, exp_wr);
    chk("cam_pin_rules", both, 0);
    chk("res_hit", res_hit, exp_hit);
    chk("res_alloc", res_alloc, exp_alloc);
    chk("res_index", res_index, exp_idx);

    snap = {res_valid, res_hit, res_alloc, res_index};
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_fields", {res_valid, res_hit, res_alloc, res_index}, snap);
      chk("hold_in_ready", in_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("after_transfer_valid", res_valid, 0);
    if (exp_hit) mhits++;
    else mmisses++;
  endtask

  initial begin
    logic [7:0] k;
    for (int i = 0; i < 16; i++) cam_mem[i] = 8'($urandom);
    cam_found = 1'($urandom);
    cam_out = 5'($urandom);
    in_data = 8'h00; in_alloc = 1'b0;

    reset_and_init();
    lookup(8'h3C, 1'b0, 0);
    lookup(8'h3C, 1'b1, 0);
    lookup(8'h3C, 1'b0, 0);

    tick();
    reset_and_init();
    for (int i = 0; i < 17; i++) lookup(8'(i), 1'b1, 0);
    lookup(8'h00, 1'b0, 0);
    lookup(8'h10, 1'b0, 0);
    lookup(8'h10, 1'b0, 5);
    lookup(8'hFF, 1'b1, 2);

    for (int n = 0; n < 80; n++) begin
      k = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 40));
      lookup(k, 1'($urandom), $urandom_range(0, 3));
    end

`ifdef CAM_LOOKUP_STATS_EN
    tick();
    chk("hit_cnt", hit_cnt, mhits);
    chk("miss_cnt", miss_cnt, mmisses);
`endif

    // Reset while the controller is in ALLOC with a write on the pins.
    while (!in_ready) tick();
    in_valid = 1'b1; in_data = 8'hA5; in_alloc = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("alloc_write", cam_write, 1);
    chk("alloc_addr", cam_addr, mvictim);
    chk("alloc_valid", res_valid, 0);
    reset_and_init();
    lookup(8'hA5, 1'b0, 0);
    lookup(8'hA5, 1'b1, 0);
    lookup(8'hA5, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $fatal(1, "FAIL global_timeout observed=timeout expected=finish");
  end

endmodule
